// File: rtl/oxide_startup_pkg.sv
// oxide_startup_pkg
//   Shared definitions for the device wake-up sequencer:
//   - state_e      : 3-bit state encodings of the sequencer FSM
//   - DEF_*        : default parameter values
//   - load_value   : counter preload for a programmed delay (0 behaves as 1)
//   - decode_outputs : {GSR, GWE, GOE, DONE} for a state plus the sticky "up" flag
package oxide_startup_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_GSR   = 3'd1,
        ST_GWEW  = 3'd2,
        ST_GOEW  = 3'd3,
        ST_DONEW = 3'd4,
        ST_DONE  = 3'd5,
        ST_UGSR  = 3'd6
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GSR_DELAY   = 4;
    localparam int DEF_GWE_DELAY   = 2;
    localparam int DEF_GOE_DELAY   = 2;
    localparam int DEF_DONE_DELAY  = 1;
    localparam int DEF_CNT_W       = 8;

    // A state that must last max(d,1) cycles is entered with cnt = max(d,1)-1
    // and leaves on the edge where cnt is already zero.
    function automatic int load_value(input int d);
        return (d <= 1) ? 0 : d - 1;
    endfunction

    // Once the device has been up, GOE and DONE stay asserted in every state.
    function automatic logic [3:0] decode_outputs(input logic [2:0] st, input logic up);
        logic gsr;
        logic gwe;
        logic goe;
        logic done;
        gsr  = 1'b0;
        gwe  = 1'b0;
        goe  = 1'b0;
        done = 1'b0;
        case (st)
            ST_RESET, ST_GSR, ST_UGSR: gsr = 1'b1;
            ST_GWEW:                   gsr = 1'b0;
            ST_GOEW:                   gwe = 1'b1;
            ST_DONEW: begin
                gwe = 1'b1;
                goe = 1'b1;
            end
            ST_DONE: begin
                gwe  = 1'b1;
                goe  = 1'b1;
                done = 1'b1;
            end
            default:                   gsr = 1'b1;
        endcase
        if (up) begin
            goe  = 1'b1;
            done = 1'b1;
        end
        return {gsr, gwe, goe, done};
    endfunction

endpackage

// File: rtl/oxide_rst_sync.sv
// oxide_rst_sync
//   Asynchronous-assert / synchronous-release reset synchroniser.
//   Ports:
//     clk      in  clock
//     rst      in  asynchronous active-high reset (clears the chain at once)
//     released out high once STAGES clock edges have passed with rst low
module oxide_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic released
);

    generate
        if (STAGES < 2) begin : g_stages_err
            $error("oxide_rst_sync: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] chain_reg;

    // A 1 is shifted in each edge; release is seen when it reaches the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], 1'b1};
        end
    end

    assign released = chain_reg[STAGES-1];

endmodule

// File: rtl/oxide_startup_seq.sv
// oxide_startup_seq
//   Device wake-up sequencer: after LSR release (synchronised) holds GSR for a
//   programmed time, then raises GWE, GOE and DONE in turn. Once up, a user
//   USRGSR request re-asserts GSR and drops GWE, then re-runs the release part
//   of the sequence while keeping GOE/DONE high.
//   Ports:
//     CLK    in   clock, rising edge
//     LSR    in   asynchronous active-high reset
//     USRGSR in   user global set/reset request (honoured in ST_DONE/ST_UGSR)
//     HOLD   in   freezes state and counter in the counting states
//     GSR    out  global set/reset
//     GWE    out  global write enable
//     GOE    out  global output enable
//     DONE   out  wake-up complete
//     STATE  out  current state encoding (debug)
module oxide_startup_seq
    import oxide_startup_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GSR_DELAY   = DEF_GSR_DELAY,
    parameter int GWE_DELAY   = DEF_GWE_DELAY,
    parameter int GOE_DELAY   = DEF_GOE_DELAY,
    parameter int DONE_DELAY  = DEF_DONE_DELAY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       LSR,
    input  logic       USRGSR,
    input  logic       HOLD,
    output logic       GSR,
    output logic       GWE,
    output logic       GOE,
    output logic       DONE,
    output logic [2:0] STATE
);

    generate
        if (GSR_DELAY >= (1 << CNT_W) || GWE_DELAY >= (1 << CNT_W) ||
            GOE_DELAY >= (1 << CNT_W) || DONE_DELAY >= (1 << CNT_W)) begin : g_delay_err
            $error("oxide_startup_seq: a delay does not fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LD_GSR  = CNT_W'(load_value(GSR_DELAY));
    localparam logic [CNT_W-1:0] LD_GWE  = CNT_W'(load_value(GWE_DELAY));
    localparam logic [CNT_W-1:0] LD_GOE  = CNT_W'(load_value(GOE_DELAY));
    localparam logic [CNT_W-1:0] LD_DONE = CNT_W'(load_value(DONE_DELAY));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             released;
    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             up_reg;
    logic             up_next;
    logic [3:0]       out_next;

    oxide_rst_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_rst_sync (
        .clk      (CLK),
        .rst      (LSR),
        .released (released)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        up_next    = up_reg;
        case (state_reg)
            ST_RESET: begin
                if (released) begin
                    state_next = ST_GSR;
                    cnt_next   = LD_GSR;
                end
            end
            ST_GSR, ST_GWEW, ST_GOEW, ST_DONEW: begin
                if (!HOLD) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end else begin
                        // Delay expired: advance and preload the next delay.
                        case (state_reg)
                            ST_GSR: begin
                                state_next = ST_GWEW;
                                cnt_next   = LD_GWE;
                            end
                            ST_GWEW: begin
                                state_next = ST_GOEW;
                                cnt_next   = LD_GOE;
                            end
                            ST_GOEW: begin
                                state_next = ST_DONEW;
                                cnt_next   = LD_DONE;
                            end
                            default: begin
                                state_next = ST_DONE;
                                cnt_next   = '0;
                                up_next    = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_DONE: begin
                if (USRGSR) begin
                    state_next = ST_UGSR;
                end
            end
            ST_UGSR: begin
                if (!USRGSR) begin
                    state_next = ST_GSR;
                    cnt_next   = LD_GSR;
                end
            end
            default: begin
                // Unused encoding recovers to reset on the next edge.
                state_next = ST_RESET;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change on the
    // same edge as the state register.
    assign out_next = decode_outputs(state_next, up_next);

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
            up_reg    <= 1'b0;
            GSR       <= 1'b1;
            GWE       <= 1'b0;
            GOE       <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            up_reg    <= up_next;
            GSR       <= out_next[3];
            GWE       <= out_next[2];
            GOE       <= out_next[1];
            DONE      <= out_next[0];
        end
    end

    assign STATE = state_reg;

endmodule

// File: tb/tb_oxide_startup_seq.sv
// tb_oxide_startup_seq
//   Scoreboard bench for oxide_startup_seq. The stimulus process pushes the
//   expected {GSR,GWE,GOE,DONE,STATE} for each upcoming clock edge; a monitor
//   pops and compares 1 time unit after that edge. Two instances: default
//   delays (dut_m) and all delays zero (dut_z).
module tb_oxide_startup_seq;

    logic CLK;
    logic lsr;
    logic lsr_z;
    logic hold;
    logic usr;

    logic       gsr_m, gwe_m, goe_m, done_m;
    logic [2:0] st_m;
    logic       gsr_z, gwe_z, goe_z, done_z;
    logic [2:0] st_z;
    logic [6:0] vm;
    logic [6:0] vz;

    assign vm = {gsr_m, gwe_m, goe_m, done_m, st_m};
    assign vz = {gsr_z, gwe_z, goe_z, done_z, st_z};

    typedef struct packed {
        int         cyc;
        logic       which;
        logic [6:0] vec;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    exp_t  mon_e;
    string mon_t;

    oxide_startup_seq dut_m (
        .CLK    (CLK),
        .LSR    (lsr),
        .USRGSR (usr),
        .HOLD   (hold),
        .GSR    (gsr_m),
        .GWE    (gwe_m),
        .GOE    (goe_m),
        .DONE   (done_m),
        .STATE  (st_m)
    );

    oxide_startup_seq #(
        .GSR_DELAY  (0),
        .GWE_DELAY  (0),
        .GOE_DELAY  (0),
        .DONE_DELAY (0)
    ) dut_z (
        .CLK    (CLK),
        .LSR    (lsr_z),
        .USRGSR (usr),
        .HOLD   (hold),
        .GSR    (gsr_z),
        .GWE    (gwe_z),
        .GOE    (goe_z),
        .DONE   (done_z),
        .STATE  (st_z)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected outputs straight from the state table: {GSR,GWE,GOE,DONE,STATE}.
    function automatic logic [6:0] ev(input logic [2:0] st, input logic up);
        logic [3:0] o;
        case (st)
            3'd0, 3'd1: o = 4'b1000;
            3'd2:       o = 4'b0000;
            3'd3:       o = 4'b0100;
            3'd4:       o = 4'b0110;
            3'd5:       o = 4'b0111;
            default:    o = 4'b1000;
        endcase
        if (up) o[1:0] = 2'b11;
        return {o, st};
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %b, expected %b", tag, $time, got, exp);
        end else begin
            $display("[TB] %s ok %b", tag, got);
        end
    endtask

    // Called at a negedge after inputs are set: expects state st for the next
    // n edges, stepping to the negedge after each.
    task automatic seg(input logic [2:0] st, input int n, input logic up,
                       input logic which, input string tag);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{cyc: cyc + 1, which: which, vec: ev(st, up)});
            tag_q.push_back(tag);
            @(negedge CLK);
        end
    endtask

    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            mon_t = tag_q.pop_front();
            check(mon_t, mon_e.which ? vz : vm, mon_e.vec);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        lsr   = 1'b1;
        lsr_z = 1'b1;
        hold  = 1'b0;
        usr   = 1'b0;
        #1;
        check("reset_m", vm, ev(3'd0, 1'b0));
        check("reset_z", vz, ev(3'd0, 1'b0));
        @(negedge CLK);

        // Default startup: GSR falls edge 7, GWE 9, GOE 11, DONE 12.
        lsr = 1'b0;
        seg(3'd0, 2, 1'b0, 1'b0, "A_sync");
        seg(3'd1, 4, 1'b0, 1'b0, "A_gsr");
        seg(3'd2, 2, 1'b0, 1'b0, "A_gwew");
        seg(3'd3, 2, 1'b0, 1'b0, "A_goew");
        seg(3'd4, 1, 1'b0, 1'b0, "A_donew");
        seg(3'd5, 2, 1'b0, 1'b0, "A_done");
        hold = 1'b1;
        seg(3'd5, 2, 1'b0, 1'b0, "A_done_hold");
        hold = 1'b0;

        // User GSR for 5 cycles, then the release part re-runs with GOE/DONE kept.
        usr = 1'b1;
        seg(3'd6, 5, 1'b1, 1'b0, "B_ugsr");
        usr = 1'b0;
        seg(3'd1, 4, 1'b1, 1'b0, "B_gsr");
        seg(3'd2, 2, 1'b1, 1'b0, "B_gwew");
        seg(3'd3, 1, 1'b1, 1'b0, "B_goew");

        // One-cycle LSR pulse in ST_GOEW: immediate reset, up flag cleared.
        lsr = 1'b1;
        #1;
        check("C_async_rst", vm, ev(3'd0, 1'b0));
        seg(3'd0, 1, 1'b0, 1'b0, "C_lsr_high");
        lsr = 1'b0;

        // Full re-run with HOLD for 3 cycles in ST_GSR (GSR falls edge 10)
        // and a USRGSR pulse in ST_GWEW that must be ignored.
        seg(3'd0, 2, 1'b0, 1'b0, "D_sync");
        seg(3'd1, 1, 1'b0, 1'b0, "D_gsr");
        hold = 1'b1;
        seg(3'd1, 3, 1'b0, 1'b0, "D_gsr_hold");
        hold = 1'b0;
        seg(3'd1, 3, 1'b0, 1'b0, "D_gsr_count");
        seg(3'd2, 1, 1'b0, 1'b0, "D_gwew");
        usr = 1'b1;
        seg(3'd2, 1, 1'b0, 1'b0, "D_gwew_usr");
        usr = 1'b0;
        seg(3'd3, 2, 1'b0, 1'b0, "D_goew");
        seg(3'd4, 1, 1'b0, 1'b0, "D_donew");
        seg(3'd5, 2, 1'b0, 1'b0, "D_done");

        // Zero delays: each counting state lasts one cycle, DONE at edge 7.
        lsr_z = 1'b0;
        seg(3'd0, 2, 1'b0, 1'b1, "E_sync");
        seg(3'd1, 1, 1'b0, 1'b1, "E_gsr");
        seg(3'd2, 1, 1'b0, 1'b1, "E_gwew");
        seg(3'd3, 1, 1'b0, 1'b1, "E_goew");
        seg(3'd4, 1, 1'b0, 1'b1, "E_donew");
        seg(3'd5, 2, 1'b0, 1'b1, "E_done");

        repeat (3) @(negedge CLK);
        check("sb_drain", 7'(sb_q.size()), 7'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
